// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch prefetch queue: bus layout,
// SRAM size encoding and the default reset PC.
package if_pkg;
  localparam int FS_TO_DS_BUS_W = 65;
  localparam int ADEF_BIT = 64;
  localparam int INST_LSB = 32;
  localparam int PC_LSB   = 0;
  localparam logic [1:0]  INST_SRAM_SIZE_WORD = 2'b10;
  localparam logic [31:0] DEFAULT_RESET_PC    = 32'h1C000000;

  function automatic logic [FS_TO_DS_BUS_W-1:0] pack_bus(input logic adef,
                                                         input logic [31:0] inst,
                                                         input logic [31:0] pc);
    return {adef, inst, pc};
  endfunction
endpackage

// File: rtl/if_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with clear, occupancy count and simultaneous push/pop
// (a push into a full FIFO is accepted when the head leaves in the same cycle).
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity lives in count_q.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage keeping up to MAX_OUT SRAM reads in flight and
// buffering returned instructions; redirects drop stale responses by count.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IBUF_DEPTH = 4,
  parameter int          MAX_OUT    = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ds_allowin,
  input  logic                      flush,
  input  logic [31:0]               flush_target,
  input  logic                      br_taken,
  input  logic [31:0]               br_target,
  input  logic                      br_stall,
  output logic                      fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus,
  output logic                      inst_sram_req,
  output logic                      inst_sram_wr,
  output logic [3:0]                inst_sram_wstrb,
  output logic [1:0]                inst_sram_size,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata,
  input  logic                      inst_sram_addr_ok,
  input  logic                      inst_sram_data_ok,
  input  logic [31:0]               inst_sram_rdata
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int IC = $clog2(IBUF_DEPTH + 1);
  localparam int PC = $clog2(MAX_OUT + 1);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d, discard_cnt_q, discard_cnt_d, fresh_out;
  logic          adef_hold_q, adef_hold_d;

  logic          redirect, handshake, keep_resp, adef_push, misaligned;
  logic [31:0]   redirect_pc;
  logic [IC-1:0] ibuf_count;
  logic          ibuf_empty, ibuf_full, ibuf_push;
  logic [FS_TO_DS_BUS_W-1:0] ibuf_push_data;
  logic [31:0]   pcq_head;
  logic [PC-1:0] pcq_count;
  logic          pcq_empty, pcq_full;
  logic          pcq_unused;

  assign redirect    = flush | br_taken;
  assign redirect_pc = flush ? flush_target : br_target;
  assign misaligned  = (pc_q[1:0] != 2'b00);
  assign fresh_out   = out_cnt_q - discard_cnt_q;

  // Credit check reserves an ibuf slot for every fresh in-flight response.
  assign inst_sram_req = resetn & ~redirect & ~br_stall & ~adef_hold_q & ~misaligned
                       & (32'(out_cnt_q) < MAX_OUT)
                       & ((32'(ibuf_count) + 32'(fresh_out)) < IBUF_DEPTH);
  assign handshake = inst_sram_req & inst_sram_addr_ok;
  assign keep_resp = inst_sram_data_ok & (discard_cnt_q == '0) & ~redirect;
  assign adef_push = ~redirect & ~adef_hold_q & misaligned & (fresh_out == '0) & ~ibuf_full;

  assign ibuf_push      = keep_resp | adef_push;
  assign ibuf_push_data = keep_resp ? pack_bus(1'b0, inst_sram_rdata, pcq_head)
                                    : pack_bus(1'b1, 32'h0, pc_q);

  assign inst_sram_addr  = pc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_size  = INST_SRAM_SIZE_WORD;
  assign inst_sram_wdata = 32'h0;
  assign fs_to_ds_valid  = ~ibuf_empty;
  assign pcq_unused      = ^{pcq_count, pcq_empty, pcq_full};

  always_comb begin
    pc_d          = pc_q;
    out_cnt_d     = out_cnt_q;
    discard_cnt_d = discard_cnt_q;
    adef_hold_d   = adef_hold_q;
    if (redirect) begin
      pc_d          = redirect_pc;
      out_cnt_d     = out_cnt_q - CW'(inst_sram_data_ok);
      discard_cnt_d = out_cnt_q - CW'(inst_sram_data_ok);
      adef_hold_d   = 1'b0;
    end else begin
      if (handshake) pc_d = pc_q + 32'd4;
      out_cnt_d = out_cnt_q + CW'(handshake) - CW'(inst_sram_data_ok);
      if (inst_sram_data_ok && discard_cnt_q != '0) discard_cnt_d = discard_cnt_q - 1'b1;
      if (adef_push) adef_hold_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q          <= RESET_PC;
      out_cnt_q     <= '0;
      discard_cnt_q <= '0;
      adef_hold_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      out_cnt_q     <= out_cnt_d;
      discard_cnt_q <= discard_cnt_d;
      adef_hold_q   <= adef_hold_d;
    end
  end

  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_pc_queue (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (redirect),
    .push      (handshake),
    .push_data (pc_q),
    .pop       (keep_resp),
    .head_data (pcq_head),
    .count     (pcq_count),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  sync_fifo #(.WIDTH(FS_TO_DS_BUS_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (redirect),
    .push      (ibuf_push),
    .push_data (ibuf_push_data),
    .pop       (fs_to_ds_valid & ds_allowin),
    .head_data (fs_to_ds_bus),
    .count     (ibuf_count),
    .empty     (ibuf_empty),
    .full      (ibuf_full)
  );
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomised bench for if_prefetch_queue: an in-order SRAM model plus a
// queue-level reference of in-flight requests and buffered instructions.
module tb_if_prefetch_queue;
  localparam int IBUF = 4;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        resetn, ds_allowin, flush, br_taken, br_stall;
  logic [31:0] flush_target, br_target;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [3:0]  inst_sram_wstrb;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;

  always #5 clk = ~clk;

  if_prefetch_queue #(.RESET_PC(32'h1C000000), .IBUF_DEPTH(IBUF), .MAX_OUT(MAXO)) dut (
    .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin), .flush(flush),
    .flush_target(flush_target), .br_taken(br_taken), .br_target(br_target),
    .br_stall(br_stall), .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } req_t;

  req_t        out_q[$];
  logic [64:0] ibuf_m[$];
  logic [64:0] deliv_log[$];
  logic [31:0] pc_m;
  bit          adef_hold_m, model_ok;
  int          vectors = 0, miscompares = 0;

  bit          s_resetn, s_flush, s_br, s_stall, s_allow;
  logic [31:0] s_ft, s_bt;
  int          p_addr, p_data;
  bit          track_first;
  logic [31:0] first_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEADBEEF;
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    int  fresh;
    bit  redirect, exp_req, hs, adef_c, data_ok_v;
    logic [31:0] tgt;
    req_t e;
    @(negedge clk);
    resetn       = s_resetn;
    flush        = s_flush;
    flush_target = s_ft;
    br_taken     = s_br;
    br_target    = s_bt;
    br_stall     = s_stall;
    ds_allowin   = s_allow;
    inst_sram_addr_ok = ($urandom_range(0, 99) < p_addr);
    data_ok_v    = s_resetn && (out_q.size() > 0) && ($urandom_range(0, 99) < p_data);
    inst_sram_data_ok = data_ok_v;
    inst_sram_rdata   = data_ok_v ? mem_word(out_q[0].addr) : $urandom;
    #1;
    redirect = s_flush || s_br;
    tgt      = s_flush ? s_ft : s_bt;
    fresh = 0;
    foreach (out_q[i]) if (!out_q[i].stale) fresh++;
    exp_req = s_resetn && !redirect && !s_stall && !adef_hold_m && (pc_m[1:0] == 2'b00)
              && (out_q.size() < MAXO) && (ibuf_m.size() + fresh < IBUF);
    adef_c  = !redirect && !adef_hold_m && (pc_m[1:0] != 2'b00) && (fresh == 0)
              && (ibuf_m.size() < IBUF);
    if (model_ok) begin
      chk("valid", 65'(fs_to_ds_valid), 65'(ibuf_m.size() > 0));
      if (ibuf_m.size() > 0) chk("bus", fs_to_ds_bus, ibuf_m[0]);
      chk("req", 65'(inst_sram_req), 65'(exp_req));
      if (exp_req) chk("addr", 65'(inst_sram_addr), 65'(pc_m));
      chk("consts", 65'({inst_sram_wr, inst_sram_wstrb, inst_sram_size, inst_sram_wdata}),
          65'({1'b0, 4'h0, 2'b10, 32'h0}));
    end
    if (fs_to_ds_valid === 1'b1 && ds_allowin) deliv_log.push_back(fs_to_ds_bus);
    if (track_first && inst_sram_req === 1'b1 && inst_sram_addr_ok) begin
      first_req_addr = inst_sram_addr;
      track_first = 0;
    end
    hs = exp_req && inst_sram_addr_ok;
    @(posedge clk);
    if (!s_resetn) begin
      out_q.delete(); ibuf_m.delete();
      pc_m = 32'h1C000000; adef_hold_m = 0; model_ok = 1; track_first = 1;
    end else begin
      if (ibuf_m.size() > 0 && s_allow) void'(ibuf_m.pop_front());
      if (data_ok_v) begin
        e = out_q.pop_front();
        if (!e.stale && !redirect) ibuf_m.push_back({1'b0, mem_word(e.addr), e.addr});
      end
      if (hs) begin
        out_q.push_back('{addr: pc_m, stale: 1'b0});
        pc_m = pc_m + 32'd4;
      end
      if (adef_c) begin
        ibuf_m.push_back({1'b1, 32'h0, pc_m});
        adef_hold_m = 1;
      end
      if (redirect) begin
        ibuf_m.delete();
        foreach (out_q[i]) out_q[i].stale = 1'b1;
        pc_m = tgt;
        adef_hold_m = 0;
      end
    end
  endtask

  task automatic idle_stim();
    s_resetn = 1; s_flush = 0; s_br = 0; s_stall = 0; s_allow = 1;
    s_ft = 32'h0; s_bt = 32'h0; p_addr = 100; p_data = 100;
  endtask

  task automatic wait_deliv(input string name, input logic [64:0] exp);
    for (int i = 0; i < 40 && deliv_log.size() == 0; i++) cycle();
    if (deliv_log.size() == 0) chk({name, "_timeout"}, 65'd0, 65'd1);
    else chk(name, deliv_log[0], exp);
  endtask

  initial begin
    model_ok = 0; track_first = 0; pc_m = 32'h0; adef_hold_m = 0;
    idle_stim();
    s_resetn = 0;
    repeat (2) cycle();
    s_resetn = 1;
    deliv_log.delete();
    // Back-to-back fetch from reset
    repeat (20) cycle();
    chk("first_req_addr", 65'(first_req_addr), 65'h1C000000);
    chk("first_deliv", deliv_log[0], {1'b0, 32'hC2ADBEEF, 32'h1C000000});
    // ID stall fills the buffer and blocks further requests
    s_allow = 0;
    repeat (15) cycle();
    #1;
    chk("stall_valid", 65'(fs_to_ds_valid), 65'd1);
    chk("stall_req", 65'(inst_sram_req), 65'd0);
    s_allow = 1;
    repeat (10) cycle();
    // Flush with two requests outstanding
    p_data = 0;
    repeat (4) cycle();
    s_flush = 1; s_ft = 32'h1C008000;
    cycle();
    s_flush = 0; p_data = 100;
    deliv_log.delete();
    wait_deliv("flush_first", {1'b0, mem_word(32'h1C008000), 32'h1C008000});
    repeat (5) cycle();
    // Misaligned branch target produces a single ADEF entry, then stalls
    s_br = 1; s_bt = 32'h1C000102;
    cycle();
    s_br = 0;
    deliv_log.delete();
    wait_deliv("adef_entry", 65'h1_00000000_1C000102);
    repeat (10) cycle();
    chk("adef_one_entry", 65'(deliv_log.size()), 65'd1);
    #1;
    chk("adef_no_req", 65'(inst_sram_req), 65'd0);
    s_flush = 1; s_ft = 32'h1C000200;
    cycle();
    s_flush = 0;
    deliv_log.delete();
    wait_deliv("adef_restart", {1'b0, 32'hC2ADBCEF, 32'h1C000200});
    // Reset mid-burst
    p_data = 50;
    repeat (6) cycle();
    s_resetn = 0;
    cycle();
    s_resetn = 1;
    #1;
    chk("rst_valid", 65'(fs_to_ds_valid), 65'd0);
    for (int i = 0; i < 20 && track_first; i++) cycle();
    chk("rst_first_req", 65'(first_req_addr), 65'h1C000000);
    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      p_addr   = 70;
      p_data   = 60;
      s_allow  = ($urandom_range(0, 99) < 70);
      s_stall  = ($urandom_range(0, 99) < 20);
      s_flush  = ($urandom_range(0, 99) < 3);
      s_br     = ($urandom_range(0, 99) < 4);
      s_resetn = ($urandom_range(0, 999) >= 5);
      s_ft = {20'h1C000, 10'($urandom), ($urandom_range(0, 99) < 85) ? 2'b00 : 2'($urandom_range(1, 3))};
      s_bt = {20'h1C001, 10'($urandom), ($urandom_range(0, 99) < 85) ? 2'b00 : 2'($urandom_range(1, 3))};
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
